hierarchical_reduce_pipe: RTL and testbench

Parametrised, pipelined successor to the 4×4-bit hierarchical datapath used in the limit-scope power tests. Reduces NUM_IN operands of WIDTH bits through a binary tree of per-level sub-instances, one register stage per level, under a selectable operator. Adds an optional accumulating output stage and a result counter. The deep, regular scope hierarchy lets scope-limited power estimation be checked against per-level activity. Data registers are load-gated on valid, so idle cycles produce no data toggles.

---
 rtl/hierarchical_reduce_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_hierarchical_reduce_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hierarchical_reduce_pipe.sv
// hierarchical_reduce_pipe
//   Pipelined binary-tree reduction of NUM_IN operands of WIDTH bits under a
//   per-vector operator (add mod 2^WIDTH, xor, and, unsigned max). The input
//   is registered once, then each tree level is its own sub-instance with one
//   register stage. A final output stage either replaces or accumulates the
//   result and counts results (saturating).
//
//   Ports:
//     clk, rst         rising-edge clock, async active-high reset
//     in_valid         operand vector valid this cycle
//     in_data          operand i = in_data[i*WIDTH +: WIDTH]
//     op               00 add, 01 xor, 10 and, 11 unsigned max
//     accumulate       out_data <= op(out_data, result) instead of result
//     clear            sync clear of accumulator/counter (an arriving result
//                      loads un-accumulated and restarts the count at 1)
//     out_valid        one-cycle pulse per result
//     out_data         result / accumulator (holds between results)
//     out_count        results since reset/clear, saturating
//
//   Latency: a vector sampled at edge t appears after edge t+LEVELS+1.
//   Data and tag registers load only with valid, so bubbles cause no toggles.

// Two-operand combiner shared by every tree node and the accumulator.
module reduce_op #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      2'b00: y = a + b;            // carry dropped by the WIDTH-bit result
      2'b01: y = a ^ b;
      2'b10: y = a & b;
      2'b11: y = (a > b) ? a : b;
      default: y = '0;
    endcase
  end
endmodule

// One tree level: N_OUT nodes combining adjacent pairs, plus one register
// stage carrying the valid bit and the vector's op/accumulate tags.
module reduce_level #(
  parameter int WIDTH = 4,
  parameter int N_OUT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2*N_OUT*WIDTH-1:0] in_data,
  input  logic [1:0]               in_op,
  input  logic                     in_acc,
  output logic                     out_valid,
  output logic [N_OUT*WIDTH-1:0]   out_data,
  output logic [1:0]               out_op,
  output logic                     out_acc
);
  logic [N_OUT-1:0][WIDTH-1:0] node_y, data_d, data_q;
  logic                        valid_d, valid_q;
  logic [1:0]                  op_d, op_q;
  logic                        acc_d, acc_q;

  for (genvar i = 0; i < N_OUT; i++) begin : g_node
    reduce_op #(.WIDTH(WIDTH)) u_op (
      .a  (in_data[2*i*WIDTH +: WIDTH]),
      .b  (in_data[(2*i+1)*WIDTH +: WIDTH]),
      .op (in_op),
      .y  (node_y[i])
    );
  end

  always_comb begin
    valid_d = in_valid;
    data_d  = data_q;
    op_d    = op_q;
    acc_d   = acc_q;
    if (in_valid) begin
      data_d = node_y;
      op_d   = in_op;
      acc_d  = in_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= '0;
      acc_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_op    = op_q;
  assign out_acc   = acc_q;
endmodule

module hierarchical_reduce_pipe #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              op,
  input  logic                    accumulate,
  input  logic                    clear,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count
);
  localparam int LEVELS = $clog2(NUM_IN);
  // All levels packed back to back: level k holds NUM_IN>>k operands.
  localparam int TREE_W = (2*NUM_IN - 1) * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
    $error("NUM_IN must be a power of two >= 2");
  end

  function automatic int lvl_off(input int k);
    return (2*NUM_IN - 2*(NUM_IN >> k)) * WIDTH;
  endfunction

  logic [TREE_W-1:0]      tree_data;
  logic [LEVELS:0]        tree_valid;
  logic [LEVELS:0][1:0]   tree_op;
  logic [LEVELS:0]        tree_acc;

  // Level 0: registered operands and tags.
  logic                    s0_valid_d, s0_valid_q;
  logic [NUM_IN*WIDTH-1:0] s0_data_d, s0_data_q;
  logic [1:0]              s0_op_d, s0_op_q;
  logic                    s0_acc_d, s0_acc_q;

  always_comb begin
    s0_valid_d = in_valid;
    s0_data_d  = s0_data_q;
    s0_op_d    = s0_op_q;
    s0_acc_d   = s0_acc_q;
    if (in_valid) begin
      s0_data_d = in_data;
      s0_op_d   = op;
      s0_acc_d  = accumulate;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      s0_op_q    <= '0;
      s0_acc_q   <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      s0_op_q    <= s0_op_d;
      s0_acc_q   <= s0_acc_d;
    end
  end

  assign tree_valid[0]                 = s0_valid_q;
  assign tree_data[NUM_IN*WIDTH-1:0]   = s0_data_q;
  assign tree_op[0]                    = s0_op_q;
  assign tree_acc[0]                   = s0_acc_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    reduce_level #(.WIDTH(WIDTH), .N_OUT(NUM_IN >> k)) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (tree_valid[k-1]),
      .in_data   (tree_data[lvl_off(k-1) +: (NUM_IN >> (k-1))*WIDTH]),
      .in_op     (tree_op[k-1]),
      .in_acc    (tree_acc[k-1]),
      .out_valid (tree_valid[k]),
      .out_data  (tree_data[lvl_off(k) +: (NUM_IN >> k)*WIDTH]),
      .out_op    (tree_op[k]),
      .out_acc   (tree_acc[k])
    );
  end

  // Output stage: root of the tree sits in the top WIDTH bits.
  logic [WIDTH-1:0] root_data, acc_y;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic [CNT_W-1:0] out_count_d, out_count_q;

  assign root_data = tree_data[TREE_W-1 -: WIDTH];

  reduce_op #(.WIDTH(WIDTH)) u_acc (
    .a  (out_data_q),
    .b  (root_data),
    .op (tree_op[LEVELS]),
    .y  (acc_y)
  );

  always_comb begin
    out_valid_d = tree_valid[LEVELS];
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (tree_valid[LEVELS]) begin
      // clear wins over accumulate: the arriving result starts afresh.
      out_data_d  = (tree_acc[LEVELS] && !clear) ? acc_y : root_data;
      out_count_d = clear ? CNT_W'(1)
                  : (out_count_q == CNT_MAX) ? out_count_q : out_count_q + 1'b1;
    end else if (clear) begin
      out_data_d  = '0;
      out_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_hierarchical_reduce_pipe.sv
// Bench for hierarchical_reduce_pipe (WIDTH=4, NUM_IN=4). A second instance
// with CNT_W=4 shares all inputs to exercise counter saturation.
module tb_hierarchical_reduce_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  op = '0;
  logic        accumulate = 1'b0;
  logic        clear = 1'b0;
  logic        out_valid, sat_valid;
  logic [3:0]  out_data, sat_data;
  logic [7:0]  out_count;
  logic [3:0]  sat_count;

  hierarchical_reduce_pipe #(.WIDTH(4), .NUM_IN(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .op(op),
    .accumulate(accumulate), .clear(clear), .out_valid(out_valid),
    .out_data(out_data), .out_count(out_count)
  );

  hierarchical_reduce_pipe #(.WIDTH(4), .NUM_IN(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .op(op),
    .accumulate(accumulate), .clear(clear), .out_valid(sat_valid),
    .out_data(sat_data), .out_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] res;
    logic [1:0] op;
    logic       acc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] mdl = '0;
  int         cnt = 0;
  int         cnt4 = 0;

  function automatic logic [3:0] apply(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    case (o)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; return s[3:0]; end
      2'b01: return a ^ b;
      2'b10: return a & b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  function automatic logic [3:0] fold(input logic [15:0] d, input logic [1:0] o);
    logic [3:0] r;
    r = d[3:0];
    for (int i = 1; i < 4; i++) r = apply(o, r, d[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  // Scoreboard monitor: pops an expectation when its due cycle arrives and
  // applies the accumulate/clear/saturation model at that edge.
  initial begin
    exp_t e;
    logic clr_s, rst_s;
    forever begin
      @(posedge clk);
      cyc   = cyc + 1;
      clr_s = clear;
      rst_s = rst;
      #1;
      if (rst || rst_s) begin
        q.delete();
        mdl = '0; cnt = 0; cnt4 = 0;
      end else begin
        while (q.size() > 0 && q[0].due < cyc) begin
          checks++; errors++;
          $display("FAIL sb_missed: due cycle %0d passed at cycle %0d without out_valid", q[0].due, cyc);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e    = q.pop_front();
          mdl  = (clr_s || !e.acc) ? e.res : apply(e.op, mdl, e.res);
          cnt  = clr_s ? 1 : ((cnt  < 255) ? cnt  + 1 : 255);
          cnt4 = clr_s ? 1 : ((cnt4 < 15)  ? cnt4 + 1 : 15);
          checks++;
          if (out_valid !== 1'b1 || out_data !== mdl || out_count !== 8'(cnt)) begin
            errors++;
            $display("FAIL sb_result cyc=%0d: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                     cyc, out_valid, out_data, out_count, mdl, cnt);
          end
          checks++;
          if (sat_valid !== 1'b1 || sat_data !== mdl || sat_count !== 4'(cnt4)) begin
            errors++;
            $display("FAIL sb_sat cyc=%0d: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                     cyc, sat_valid, sat_data, sat_count, mdl, cnt4);
          end
        end else begin
          if (clr_s) begin mdl = '0; cnt = 0; cnt4 = 0; end
          checks++;
          if (out_valid !== 1'b0 || out_data !== mdl || out_count !== 8'(cnt)) begin
            errors++;
            $display("FAIL sb_idle cyc=%0d: got v=%b d=%h c=%0d, want v=0 d=%h c=%0d",
                     cyc, out_valid, out_data, out_count, mdl, cnt);
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] o,
                      input logic a, input logic c);
    @(posedge clk); #1;
    in_valid = v; in_data = d; op = o; accumulate = a; clear = c;
    if (v) q.push_back('{due: cyc + 4, res: fold(d, o), op: o, acc: a});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_count !== 8'h0 || sat_count !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h c=%0d sc=%0d, want all 0", out_valid, out_data, out_count, sat_count);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_latency();
    step(1'b1, pack(4'h3, 4'h5, 4'h7, 4'h9), 2'b00, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      checks++;
      if (out_valid !== (i == 4)) begin
        errors++;
        $display("FAIL latency_valid +%0d: got %b want %b", i, out_valid, (i == 4));
      end
      if (i == 4) begin
        checks++;
        if (out_data !== 4'h8 || out_count !== 8'd1) begin
          errors++;
          $display("FAIL latency_data: got d=%h c=%0d want d=8 c=1", out_data, out_count);
        end
      end
    end
  endtask

  task automatic test_ops_back_to_back();
    logic [3:0] got[$];
    logic [3:0] want[4] = '{4'h4, 4'hF, 4'hA, 4'hC};
    do_reset();
    step(1'b1, pack(4'hF, 4'hE, 4'h7, 4'hD), 2'b10, 1'b0, 1'b0);
    step(1'b1, pack(4'h1, 4'h2, 4'h4, 4'h8), 2'b01, 1'b0, 1'b0);
    step(1'b1, pack(4'h3, 4'hA, 4'h5, 4'h9), 2'b11, 1'b0, 1'b0);
    step(1'b1, pack(4'hF, 4'hF, 4'hF, 4'hF), 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (out_valid === 1'b1) got.push_back(out_data);
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL ops_count: got %0d results want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL ops_result[%0d]: got %h want %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_accum_wrap();
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, pack(4'h1, 4'h1, 4'h1, 4'h1), 2'b00, 1'b1, 1'b0);
    idle(6);
    checks++;
    if (out_data !== 4'h0 || out_count !== 8'd32) begin
      errors++;
      $display("FAIL accum_final: got d=%h c=%0d want d=0 c=32", out_data, out_count);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] d;
    logic [3:0]  last;
    do_reset();
    last = '0;
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      last = fold(d, 2'b00);
      step(1'b1, d, 2'b00, 1'b0, 1'b0);
    end
    idle(6);
    checks++;
    if (sat_count !== 4'd15 || out_count !== 8'd20 || sat_data !== last) begin
      errors++;
      $display("FAIL saturation: got sc=%0d c=%0d sd=%h want sc=15 c=20 sd=%h",
               sat_count, out_count, sat_data, last);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1);
    idle(1);
    checks++;
    if (out_data !== 4'h0 || out_count !== 8'd0 || sat_count !== 4'd0) begin
      errors++;
      $display("FAIL clear_idle: got d=%h c=%0d sc=%0d want 0 0 0", out_data, out_count, sat_count);
    end
    step(1'b1, pack(4'h7, 4'h0, 4'h0, 4'h0), 2'b00, 1'b0, 1'b0);
    idle(5);
    step(1'b1, pack(4'h2, 4'h2, 4'h2, 4'h2), 2'b00, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1);   // clear lands on the arrival edge
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h8 || out_count !== 8'd1) begin
      errors++;
      $display("FAIL clear_arrival: got v=%b d=%h c=%0d want v=1 d=8 c=1", out_valid, out_data, out_count);
    end
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 10; i++) begin
      idle(1);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h8) begin
        errors++;
        $display("FAIL bubble_hold[%0d]: got v=%b d=%h want v=0 d=8", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, pack(4'h1, 4'h2, 4'h3, 4'h4), 2'b00, 1'b0, 1'b0);
    step(1'b1, pack(4'h5, 4'h6, 4'h7, 4'h8), 2'b01, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h c=%0d want all 0", out_valid, out_data, out_count);
    end
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_replay[%0d]: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops_back_to_back();
    test_accum_wrap();
    test_saturation();
    test_clear();
    test_bubbles();
    test_reset_midflight();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
